// File: rtl/tmod_master.sv
// Bus master for the TMOD slave: queues host commands in a small FIFO and
// runs each one through an issue/wait/respond handshake with a timeout.
module tmod_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_opnd,
  output logic [2:0] op,
  output logic [7:0] opnd,
  input  logic [1:0] status,
  input  logic       valid,
  input  logic       ready,
  output logic       rsp_valid,
  output logic [2:0] rsp_op,
  output logic [1:0] rsp_status,
  output logic       rsp_timeout,
  output logic       spurious
);

  localparam logic [2:0]  TMOD_NOP = 3'd0;
  localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t        state;
  logic [7:0]    tmo_cnt;
  logic [2:0]    hold_op;

  logic [2:0]    mem_op   [FIFO_DEPTH];
  logic [7:0]    mem_opnd [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  // NOP commands are swallowed at the FIFO input; the host still sees them accepted.
  assign cmd_ready = (count != FULL_CNT);
  assign push      = cmd_valid && cmd_ready && (cmd_op != TMOD_NOP);
  assign pop       = (state == S_IDLE) && (count != '0) && ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_op[wr_ptr]   <= cmd_op;
      mem_opnd[wr_ptr] <= cmd_opnd;
    end
  end

  // Handshake FSM; all bus and response outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      tmo_cnt     <= '0;
      op          <= TMOD_NOP;
      opnd        <= '0;
      rsp_valid   <= 1'b0;
      rsp_op      <= TMOD_NOP;
      rsp_status  <= '0;
      rsp_timeout <= 1'b0;
      spurious    <= 1'b0;
    end else begin
      if (valid && (state != S_WAIT)) spurious <= 1'b1;
      rsp_valid <= 1'b0;
      op        <= TMOD_NOP;
      opnd      <= '0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            hold_op <= mem_op[rd_ptr];
            op      <= mem_op[rd_ptr];
            opnd    <= mem_opnd[rd_ptr];
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmo_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          // A completion on the last allowed cycle still beats the timeout.
          if (valid) begin
            rsp_valid   <= 1'b1;
            rsp_op      <= hold_op;
            rsp_status  <= status;
            rsp_timeout <= 1'b0;
            state       <= S_RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            rsp_valid   <= 1'b1;
            rsp_op      <= hold_op;
            rsp_status  <= 2'b00;
            rsp_timeout <= 1'b1;
            state       <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/tmod_master.md
TMOD_MASTER -- requirements
Module: tmod_master

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: command FIFO entries, power of two, 2..16.
REQ-002 Parameter TIMEOUT, default 255: maximum WAIT cycles before abort, 1..255.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  host offers a command.
REQ-006 cmd_ready  out  1  FIFO can accept a command.
REQ-007 cmd_op  in  TMOD_OP  host opcode (defs.sv: TMOD_NOP=0, TMOD_RESET=1, TMOD_READ=2, TMOD_SETHI=3, TMOD_SETLO=4).
REQ-008 cmd_opnd  in  8  host operand.
REQ-009 op  out  TMOD_OP  bus opcode to slave (Master modport side).
REQ-010 opnd  out  8  bus operand to slave.
REQ-011 status  in  2  slave completion status.
REQ-012 valid  in  1  slave completion strobe.
REQ-013 ready  in  1  slave can take a new op.
REQ-014 rsp_valid  out  1  one-cycle response pulse.
REQ-015 rsp_op  out  TMOD_OP  opcode the response belongs to.
REQ-016 rsp_status  out  2  captured slave status; 2'b00 on timeout.
REQ-017 rsp_timeout  out  1  response produced by timeout abort.
REQ-018 spurious  out  1  sticky: slave valid seen outside WAIT; cleared only by reset.

Function
REQ-019 Host push occurs on cycle with cmd_valid=1 and cmd_ready=1; cmd_ready = FIFO not full (independent of same-cycle pop).
REQ-020 Pushed TMOD_NOP commands are discarded: no FIFO entry, no bus activity, no response.
REQ-021 FIFO is first-in first-out; pointers wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-022 FSM states IDLE, ISSUE, WAIT, RESP; encoding free.
REQ-023 IDLE: if FIFO non-empty and ready=1 -> pop head into holding register, go ISSUE; else stay.
REQ-024 ISSUE (exactly one cycle): op/opnd = held command; go WAIT; timeout counter cleared to 0.
REQ-025 op = TMOD_NOP and opnd = 8'h00 in every state except ISSUE.
REQ-026 WAIT: valid=1 -> capture status, go RESP; else if counter = TIMEOUT-1 -> go RESP with timeout flag; else counter +1.
REQ-027 Valid and timeout in the same WAIT cycle: valid wins, rsp_timeout=0.
REQ-028 RESP (one cycle): rsp_valid=1, rsp_op=held op, rsp_status=captured status (2'b00 if timeout), rsp_timeout=flag; go IDLE.
REQ-029 rsp_* other than rsp_valid hold their last values when rsp_valid=0.
REQ-030 Minimum latency: head entry with ready=1 in IDLE at cycle N -> op on bus N+1 -> valid at N+2 earliest -> rsp_valid at N+3.
REQ-031 Push from empty FIFO at cycle N is visible to the FSM at N+1 (no bypass).
REQ-032 Slave valid in IDLE, ISSUE, or RESP is ignored for responses and sets spurious.
REQ-033 ready is sampled only in IDLE; ready=0 stalls in IDLE indefinitely, no timeout.
REQ-034 Host pushes continue during ISSUE/WAIT/RESP; push into a full FIFO is not accepted.

Reset
REQ-035 On reset=1 at a clock edge: state IDLE, FIFO empty, counter 0, cmd_ready=1, op=TMOD_NOP, opnd=0, rsp_valid=0, rsp_op=TMOD_NOP, rsp_status=0, rsp_timeout=0, spurious=0.
REQ-036 Reset mid-operation (any state) discards the in-flight command and all queued commands; no response is emitted for them.
REQ-037 Reset takes priority over every concurrent event, including push and valid.

Verification
REQ-038 Push READ/0x00 with ready=1; slave valid one cycle after op with status=2'b01 -> op=TMOD_READ for exactly one cycle, rsp_valid one cycle later with rsp_op=READ, rsp_status=01, rsp_timeout=0.
REQ-039 Push 5 commands back-to-back with ready=0 (FIFO_DEPTH=4) -> 4 accepted, cmd_ready=0 after the 4th, no op driven; raise ready -> SETHI/SETLO/... issued in push order.
REQ-040 Issue SETHI/0x50, slave never asserts valid -> rsp_valid exactly TIMEOUT cycles after the ISSUE cycle (+1 for RESP), rsp_timeout=1, rsp_status=00.
REQ-041 Valid asserted on the final WAIT cycle (counter=TIMEOUT-1) -> normal response, rsp_timeout=0.
REQ-042 Valid pulsed while IDLE -> spurious=1 and stays set; no rsp_valid.
REQ-043 Assert reset during WAIT with 3 queued commands -> next cycle all outputs at reset values, no rsp_valid; a later slave valid sets spurious.
